serial_sub: RTL and testbench

- Bit-serial N-bit subtractor: computes diff = a - b - bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- This is the subtraction counterpart of the team's behavioural full adder.
- Sits in the arithmetic block library; operands arrive on a valid/ready input handshake and results leave on a valid/ready output handshake.

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/full_sub.sv | 13 +
 rtl/serial_sub.sv | 127 ++++++++++++
 tb/tb_serial_sub.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and
// the counter-width helper.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/full_sub.sv
// Single-bit full subtractor cell: d = x - y - bi, bo = borrow out.
module full_sub (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor (LSB first) with valid/ready on both sides;
// one full_sub cell and a borrow flop do the arithmetic.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] diff,
   output logic         bout,
   output logic         zero,
   output logic         busy
);

   localparam int              CW   = cnt_width(W);
   localparam logic [CW-1:0]   LAST = CW'(W - 1);

   state_e         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic [W-1:0]   acc_q, acc_d, diff_q, diff_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           br_q, br_d, bout_q, bout_d, zero_q, zero_d;
   logic           d_s, bo_s;
   logic [W:0]     shift_s;

   full_sub u_cell (
      .x  (a_q[0]),
      .y  (b_q[0]),
      .bi (br_q),
      .d  (d_s),
      .bo (bo_s)
   );

   // New difference bit enters at the MSB; the working register only
   // becomes the visible result once the last bit is in.
   assign shift_s = {d_s, acc_q};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bout_d  = bout_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               br_d    = bin;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = bo_s;
            acc_d = shift_s[W:1];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               diff_d  = shift_s[W:1];
               bout_d  = bo_s;
               zero_d  = (shift_s[W:1] == '0);
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         zero_q  <= zero_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub at W=4 and W=1, plus an exhaustive
// check of the full_sub cell.
module tb_serial_sub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       iv4, ir4, ov4, or4, bin4, bout4, zero4, busy4;
   logic [3:0] a4, b4, diff4;
   logic       iv1, ir1, ov1, or1, bin1, bout1, zero1, busy1;
   logic [0:0] a1, b1, diff1;
   logic       fx, fy, fbi, fd, fbo;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int rand_mism = 0;
   bit rand_phase = 1'b0;

   logic [5:0] q4[$];
   logic [2:0] q1[$];

   serial_sub #(.W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
      .a(a4), .b(b4), .bin(bin4), .out_valid(ov4), .out_ready(or4),
      .diff(diff4), .bout(bout4), .zero(zero4), .busy(busy4)
   );

   serial_sub #(.W(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
      .a(a1), .b(b1), .bin(bin1), .out_valid(ov1), .out_ready(or1),
      .diff(diff1), .bout(bout1), .zero(zero1), .busy(busy1)
   );

   full_sub u_fs (.x(fx), .y(fy), .bi(fbi), .d(fd), .bo(fbo));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   // Scoreboard monitors: a result is consumed on the edge after a
   // negedge that sees out_valid && out_ready.
   always @(negedge clk) begin
      if (rst_n && ov4 && or4) begin
         if (q4.size() == 0) begin
            check("sb4_unexpected", {bout4, zero4, diff4}, 32'hFFFF);
         end else begin
            logic [5:0] e;
            e = q4.pop_front();
            if (rand_phase && ({bout4, zero4, diff4} !== e)) rand_mism++;
            check("sb4_result", {bout4, zero4, diff4}, e);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && ov1 && or1) begin
         if (q1.size() == 0) begin
            check("sb1_unexpected", {bout1, zero1, diff1}, 32'hFFFF);
         end else begin
            logic [2:0] e;
            e = q1.pop_front();
            if (rand_phase && ({bout1, zero1, diff1} !== e)) rand_mism++;
            check("sb1_result", {bout1, zero1, diff1}, e);
         end
      end
   end

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                      input logic [3:0] ed, input logic eb, input logic ez,
                      input int stall, input bit bp);
      int n;
      n = 0;
      while (!ir4 && n < 50) begin @(posedge clk); #1; n++; end
      check("in_ready4_wait", ir4, 1);
      a4 = a; b4 = b; bin4 = bin; iv4 = 1'b1;
      q4.push_back({eb, ez, ed});
      @(posedge clk); #1;
      iv4 = 1'b0;
      n = 0;
      while (!ov4 && n < 50) begin @(posedge clk); #1; n++; end
      check("latency4", n, 4);
      if (ov4) begin
         for (int s = 0; s < stall; s++) begin
            if (bp) begin iv4 = 1'b1; a4 = 4'd1; b4 = 4'd1; end
            @(posedge clk); #1;
            if (bp) begin
               check("bp_diff", diff4, ed);
               check("bp_in_ready", ir4, 0);
               check("bp_busy", busy4, 1);
               check("bp_out_valid", ov4, 1);
            end
         end
         iv4 = 1'b0;
         or4 = 1'b1;
         @(posedge clk); #1;
         or4 = 1'b0;
         if (bp) begin
            check("post_hs_in_ready", ir4, 1);
            check("post_hs_busy", busy4, 0);
            check("post_hs_out_valid", ov4, 0);
         end
      end
   endtask

   task automatic op1(input logic a, input logic b, input logic bin, input int stall);
      int n;
      logic [1:0] r;
      r = {1'b0, a} - {1'b0, b} - {1'b0, bin};
      n = 0;
      while (!ir1 && n < 50) begin @(posedge clk); #1; n++; end
      check("in_ready1_wait", ir1, 1);
      a1 = a; b1 = b; bin1 = bin; iv1 = 1'b1;
      q1.push_back({r[1], (r[0] == 1'b0), r[0]});
      @(posedge clk); #1;
      iv1 = 1'b0;
      n = 0;
      while (!ov1 && n < 50) begin @(posedge clk); #1; n++; end
      check("latency1", n, 1);
      if (ov1) begin
         repeat (stall) begin @(posedge clk); #1; end
         or1 = 1'b1;
         @(posedge clk); #1;
         or1 = 1'b0;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [4:0] r;
      logic [3:0] ra, rb;
      logic       rbin;
      rst_n = 1'b1;
      iv4 = 1'b0; or4 = 1'b0; a4 = 4'd0; b4 = 4'd0; bin4 = 1'b0;
      iv1 = 1'b0; or1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
      fx = 1'b0; fy = 1'b0; fbi = 1'b0;
      #2 rst_n = 1'b0;
      #10;
      check("rst_in_ready", ir4, 1);
      check("rst_out_valid", ov4, 0);
      check("rst_busy", busy4, 0);
      check("rst_result", {bout4, zero4, diff4}, 6'd0);

      for (int i = 0; i < 8; i++) begin
         int e;
         fx = i[2]; fy = i[1]; fbi = i[0];
         #1;
         e = int'(fx) - int'(fy) - int'(fbi);
         check("full_sub", {fbo, fd}, {(e < 0), e[0]});
      end

      #8 rst_n = 1'b1;
      @(posedge clk); #1;

      op4(4'd9, 4'd3, 1'b0, 4'd6,  1'b0, 1'b0, 0, 1'b0);
      op4(4'd3, 4'd9, 1'b0, 4'hA,  1'b1, 1'b0, 1, 1'b0);
      op4(4'd5, 4'd5, 1'b0, 4'd0,  1'b0, 1'b1, 0, 1'b0);
      op4(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0, 0, 1'b0);
      op4(4'd12, 4'd4, 1'b0, 4'd8, 1'b0, 1'b0, 3, 1'b1);

      // Abort an operation two cycles into RUN; it must leave no result.
      a4 = 4'd9; b4 = 4'd1; bin4 = 1'b0; iv4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", ov4, 0);
      check("midrst_in_ready", ir4, 1);
      check("midrst_diff", diff4, 0);
      check("midrst_busy", busy4, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      op4(4'd7, 4'd2, 1'b0, 4'd5, 1'b0, 1'b0, 0, 1'b0);

      rand_phase = 1'b1;
      for (int k = 0; k < 200; k++) begin
         ra   = 4'($urandom_range(0, 15));
         rb   = 4'($urandom_range(0, 15));
         rbin = 1'($urandom_range(0, 1));
         r = {1'b0, ra} - {1'b0, rb} - {4'd0, rbin};
         op4(ra, rb, rbin, r[3:0], r[4], (r[3:0] == 4'd0), $urandom_range(0, 3), 1'b0);
      end
      for (int k = 0; k < 200; k++) begin
         op1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end
      repeat (3) @(posedge clk);
      rand_phase = 1'b0;
      $display("random sweep mismatches: %0d", rand_mism);
      check("rand_mismatches", rand_mism, 0);
      check("sb4_drained", q4.size(), 0);
      check("sb1_drained", q1.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
